// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_pkg
// Description : Shared AXI constants, burst-reader state encoding and the
//               4 KB-aware burst length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of beats for the next burst: limited by the beats still owed,
    // the burst cap, and the beats left before the next 4 KB page boundary.
    // addr_lo is the page offset in bytes, size_log2 is log2(bytes per beat).
    function automatic logic [8:0] burst_beats(
        input logic [31:0] remaining,
        input logic [11:0] addr_lo,
        input logic [2:0]  size_log2,
        input logic [8:0]  max_burst
    );
        logic [12:0] to_boundary;
        logic [31:0] beats;
        to_boundary = (13'd4096 - {1'b0, addr_lo}) >> size_log2;
        beats = remaining;
        if (beats > {23'd0, max_burst}) begin
            beats = {23'd0, max_burst};
        end
        if (beats > {19'd0, to_boundary}) begin
            beats = {19'd0, to_boundary};
        end
        return beats[8:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_reader
// Description : Turns one read descriptor (address, beat count, id) into a
//               sequence of AXI4 INCR read bursts that never cross a 4 KB
//               boundary, limits outstanding bursts, and forwards returned
//               read data as an AXI-Stream with tlast on the final beat.
// Ports       : clk/rst          - clock, synchronous active-high reset
//               s_desc_*         - descriptor handshake (accepted in IDLE)
//               m_axi_ar*        - AXI read address channel
//               m_axi_r*         - AXI read data channel
//               m_axis_*         - output stream
//               status_*         - completion pulse, error flag, busy
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_reader
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_desc_addr,
    input  logic [LEN_WIDTH-1:0]  s_desc_len,
    input  logic [ID_WIDTH-1:0]   s_desc_id,
    input  logic                  s_desc_valid,
    output logic                  s_desc_ready,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    output logic [0:0]            m_axi_aruser,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,

    output logic                  status_valid,
    output logic                  status_error,
    output logic                  status_busy
);

    localparam int          BYTES = DATA_WIDTH / 8;
    localparam logic [2:0]  SIZE  = 3'($clog2(BYTES));
    localparam int          OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int          REM_W = LEN_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [REM_W-1:0]      rem_q,   rem_d;
    logic [LEN_WIDTH-1:0]  len_q,   len_d;
    logic [ID_WIDTH-1:0]   id_q,    id_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [LEN_WIDTH-1:0]  beat_q,  beat_d;
    logic                  err_q,   err_d;

    logic [8:0] w_beats;
    logic       w_ar_hs;
    logic       w_r_win;
    logic       w_r_hs;
    logic       w_rlast_hs;

    assign w_beats = burst_beats(32'(rem_q), addr_q[11:0], SIZE, 9'(MAX_BURST_LEN));

    // AR fields derive only from addr_q/rem_q, which move only on the
    // handshake, so they are stable while arvalid waits for arready.
    // Outstanding can only fall while waiting, so arvalid never retracts.
    assign m_axi_arvalid  = (state_q == ISSUE) && (outst_q < OUT_W'(MAX_OUTSTANDING));
    assign m_axi_arid     = id_q;
    assign m_axi_araddr   = addr_q;
    assign m_axi_arlen    = 8'(w_beats - 9'd1);
    assign m_axi_arsize   = SIZE;
    assign m_axi_arburst  = BURST_INCR;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'b0011;
    assign m_axi_arprot   = 3'b010;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arregion = 4'd0;
    assign m_axi_aruser   = 1'b0;

    assign w_ar_hs = m_axi_arvalid & m_axi_arready;

    // Read data is only taken while a transfer is in flight.
    assign w_r_win       = (state_q == ISSUE) || (state_q == DRAIN);
    assign m_axi_rready  = m_axis_tready & w_r_win;
    assign m_axis_tvalid = m_axi_rvalid & w_r_win;
    assign m_axis_tdata  = m_axi_rdata;
    // Stream framing follows the descriptor, not the individual bursts.
    assign m_axis_tlast  = (beat_q == len_q);

    assign w_r_hs     = m_axi_rvalid & m_axi_rready;
    assign w_rlast_hs = w_r_hs & m_axi_rlast;

    assign s_desc_ready = (state_q == IDLE);
    assign status_valid = (state_q == DONE);
    assign status_error = err_q;
    assign status_busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        id_d    = id_q;
        outst_d = outst_q;
        beat_d  = beat_q;
        err_d   = err_q;

        case ({w_ar_hs, w_rlast_hs})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        if (w_r_hs) begin
            beat_d = beat_q + LEN_WIDTH'(1);
            if ((m_axi_rresp != RESP_OKAY) || (m_axi_rid != id_q)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (s_desc_valid) begin
                    addr_d  = s_desc_addr;
                    rem_d   = {1'b0, s_desc_len} + REM_W'(1);
                    len_d   = s_desc_len;
                    id_d    = s_desc_id;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (w_ar_hs) begin
                    addr_d = addr_q + (ADDR_WIDTH'(w_beats) << SIZE);
                    rem_d  = rem_q - REM_W'(w_beats);
                    if (rem_d == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outst_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
            outst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            id_q    <= id_d;
            outst_q <= outst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_reader
// Description : Self-checking bench for axi_burst_reader with a randomised
//               AXI read slave, a descriptor-level reference model and
//               directed boundary scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_reader;

    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam int IW   = 8;
    localparam int LW   = 16;
    localparam int MBL  = 16;
    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] s_desc_addr  = '0;
    logic [LW-1:0] s_desc_len   = '0;
    logic [IW-1:0] s_desc_id    = '0;
    logic          s_desc_valid = 1'b0;
    logic          s_desc_ready;
    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [3:0]    arqos;
    logic [3:0]    arregion;
    logic [0:0]    aruser;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [IW-1:0] rid     = '0;
    logic [DW-1:0] rdata   = '0;
    logic [1:0]    rresp   = 2'b00;
    logic          rlast   = 1'b0;
    logic          rvalid  = 1'b0;
    logic          rready;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready  = 1'b0;
    logic          status_valid;
    logic          status_error;
    logic          status_busy;

    axi_burst_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LEN_WIDTH(LW),
        .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_desc_addr(s_desc_addr), .s_desc_len(s_desc_len), .s_desc_id(s_desc_id),
        .s_desc_valid(s_desc_valid), .s_desc_ready(s_desc_ready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
        .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arqos(arqos),
        .m_axi_arregion(arregion), .m_axi_aruser(aruser),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .status_valid(status_valid), .status_error(status_error),
        .status_busy(status_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t         exp_ar[$];
    ar_t         ar_log[$];
    int          cur_len     = 0;
    logic [7:0]  cur_id      = '0;
    logic [31:0] tag         = '0;
    int          beats_seen  = 0;
    bit          exp_err     = 1'b0;
    bit          desc_active = 1'b0;
    bit          status_seen = 1'b0;
    bit          last_err    = 1'b0;
    int          outst       = 0;

    // ---------------- slave state ----------------
    int burst_q[$];
    int bbeat    = 0;
    int slv_k    = 0;
    int err_beat = -1;
    bit withhold = 1'b0;
    bit ar_hs, r_hs, r_last_s;

    function automatic logic [63:0] data_for(input int k);
        return {tag, 32'(k)};
    endfunction

    // Expected burst split: beats limited by what is left, the burst cap and
    // the room left in the current 4 KB page.
    task automatic build_expect(input logic [31:0] addr, input int len);
        int a, r, b, room;
        exp_ar.delete();
        a = int'(addr);
        r = len + 1;
        while (r > 0) begin
            room = (4096 - (a % 4096)) / (DW / 8);
            b = r;
            if (b > MBL)  b = MBL;
            if (b > room) b = room;
            exp_ar.push_back('{addr: 32'(a), len: 8'(b - 1)});
            a = a + b * (DW / 8);
            r = r - b;
        end
    endtask

    // ---------------- monitor + slave ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                ar_hs    = arvalid && arready;
                r_hs     = rvalid && rready;
                r_last_s = rlast;
                if (outst >= MAXO) chk("ar_throttle", 64'(arvalid), 64'(0));
                if (arvalid) begin
                    if (exp_ar.size() == 0) begin
                        chk("ar_unexpected", 64'(arvalid), 64'(0));
                    end else begin
                        chk("araddr",  64'(araddr),  64'(exp_ar[0].addr));
                        chk("arlen",   64'(arlen),   64'(exp_ar[0].len));
                        chk("arid",    64'(arid),    64'(cur_id));
                        chk("arsize",  64'(arsize),  64'(3));
                        chk("arburst", 64'(arburst), 64'(1));
                        chk("arcache", 64'({arlock, arcache, arprot, arqos, arregion, aruser}),
                            64'({1'b0, 4'b0011, 3'b010, 4'd0, 4'd0, 1'b0}));
                    end
                end
                if (ar_hs && exp_ar.size() > 0) begin
                    ar_log.push_back('{addr: araddr, len: arlen});
                    burst_q.push_back(int'(arlen));
                    exp_ar.pop_front();
                    outst++;
                end
                if (tvalid && tready) begin
                    if (!desc_active) begin
                        chk("beat_unexpected", 64'(tvalid), 64'(0));
                    end else begin
                        chk("tdata", tdata, data_for(beats_seen));
                        chk("tlast", 64'(tlast), 64'(beats_seen == cur_len));
                        beats_seen++;
                    end
                end
                if (r_hs && r_last_s) outst--;
                if (status_valid) begin
                    if (!desc_active) begin
                        chk("status_unexpected", 64'(status_valid), 64'(0));
                    end else begin
                        chk("status_error", 64'(status_error), 64'(exp_err));
                        chk("status_beats", 64'(beats_seen), 64'(cur_len + 1));
                        chk("status_ars_left", 64'(exp_ar.size()), 64'(0));
                        last_err    = status_error;
                        desc_active = 1'b0;
                        status_seen = 1'b1;
                    end
                end
            end else begin
                ar_hs = 1'b0;
                r_hs  = 1'b0;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                burst_q.delete();
                bbeat  = 0;
                slv_k  = 0;
                outst  = 0;
                rvalid = 1'b0;
                rlast  = 1'b0;
            end else begin
                if (r_hs) begin
                    if (r_last_s) begin
                        void'(burst_q.pop_front());
                        bbeat = 0;
                    end else begin
                        bbeat++;
                    end
                    slv_k++;
                    rvalid = 1'b0;
                end
                arready = ($urandom_range(0, 3) != 0);
                tready  = ($urandom_range(0, 4) != 0);
                if (!rvalid && !withhold && burst_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    rvalid = 1'b1;
                    rdata  = data_for(slv_k);
                    rid    = cur_id;
                    rresp  = (slv_k == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (bbeat == burst_q[0]);
                end
            end
        end
    end

    // ---------------- descriptor tasks ----------------
    task automatic send_desc(input logic [31:0] addr, input int len, input logic [7:0] id, input int eb);
        bit acc;
        build_expect(addr, len);
        ar_log.delete();
        cur_len     = len;
        cur_id      = id;
        tag         = $urandom;
        beats_seen  = 0;
        err_beat    = eb;
        exp_err     = (eb >= 0) && (eb <= len);
        status_seen = 1'b0;
        slv_k       = 0;
        desc_active = 1'b1;
        s_desc_addr  = addr;
        s_desc_len   = LW'(len);
        s_desc_id    = id;
        s_desc_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = s_desc_ready;
            @(posedge clk);
            #1;
        end
        s_desc_valid = 1'b0;
        if (!acc) chk("desc_accept", 64'(0), 64'(1));
        @(negedge clk);
        chk("busy_after_accept", 64'({s_desc_ready, status_busy}), 64'(2'b01));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk);
            seen = status_seen;
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        #1;
    endtask

    task automatic expect_ar(input int idx, input logic [31:0] a, input logic [7:0] l);
        if (ar_log.size() > idx) begin
            chk("lit_araddr", 64'(ar_log[idx].addr), 64'(a));
            chk("lit_arlen",  64'(ar_log[idx].len),  64'(l));
        end else begin
            chk("lit_ar_count", 64'(ar_log.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({arvalid, status_valid, status_busy}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", 64'({arvalid, status_valid, status_busy, s_desc_ready}), 64'(4'b0001));
        @(posedge clk);
        #1;

        // Single aligned burst
        send_desc(32'h1000, 3, 8'h11, -1);
        wait_done();
        expect_ar(0, 32'h1000, 8'd3);
        chk("lit_ar_n1",  64'(ar_log.size()), 64'(1));
        chk("lit_beats1", 64'(beats_seen), 64'(4));
        chk("lit_err1",   64'(last_err), 64'(0));

        // Split at the 4 KB boundary
        send_desc(32'h0FF0, 7, 8'h22, -1);
        wait_done();
        expect_ar(0, 32'h0FF0, 8'd1);
        expect_ar(1, 32'h1000, 8'd5);
        chk("lit_beats2", 64'(beats_seen), 64'(8));

        // Burst cap splitting
        send_desc(32'h2000, 39, 8'h33, -1);
        wait_done();
        expect_ar(0, 32'h2000, 8'd15);
        expect_ar(1, 32'h2080, 8'd15);
        expect_ar(2, 32'h2100, 8'd7);
        chk("lit_beats3", 64'(beats_seen), 64'(40));

        // Outstanding limit with R withheld
        withhold = 1'b1;
        send_desc(32'h3000, 39, 8'h44, -1);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            got = (ar_log.size() >= 2);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("lim_ar_count", 64'(ar_log.size()), 64'(2));
        chk("lim_arvalid",  64'(arvalid), 64'(0));
        @(posedge clk);
        #1;
        withhold = 1'b0;
        wait_done();
        chk("lim_ar_total", 64'(ar_log.size()), 64'(3));

        // Error response on beat 2 of 4
        send_desc(32'h4000, 3, 8'h55, 1);
        wait_done();
        chk("lit_err5",   64'(last_err), 64'(1));
        chk("lit_beats5", 64'(beats_seen), 64'(4));

        // Error flag cleared by next descriptor; single-beat descriptor
        send_desc(32'h4FF8, 0, 8'h56, -1);
        wait_done();
        expect_ar(0, 32'h4FF8, 8'd0);
        chk("lit_err6",   64'(last_err), 64'(0));
        chk("lit_beats6", 64'(beats_seen), 64'(1));

        // Reset mid-transfer
        send_desc(32'h5000, 7, 8'h66, -1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            got = (beats_seen >= 2);
        end
        if (!got) chk("mid_reset_wait", 64'(0), 64'(1));
        #1;
        rst = 1'b1;
        desc_active = 1'b0;
        exp_ar.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_reset_outputs", 64'({arvalid, status_busy}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_reset", 64'({arvalid, status_valid, status_busy}), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        send_desc(32'h6000, 3, 8'h77, -1);
        wait_done();
        expect_ar(0, 32'h6000, 8'd3);
        chk("lit_beats7", 64'(beats_seen), 64'(4));

        // Randomised descriptors
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            int          l;
            int          eb;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($urandom_range(1, 7) * 4096 - 8 * $urandom_range(1, 24));
            end else begin
                a = 32'($urandom_range(0, 32'h7FFF)) & 32'hFFFF_FFF8;
            end
            l  = $urandom_range(0, 70);
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : -1;
            send_desc(a, l, 8'($urandom), eb);
            wait_done();
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
